// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] dest,
                                     input logic       use_src,
                                     input logic [4:0] src);
    return (dest != REG_ZERO) && use_src && (dest == src);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Tracks HI/LO occupancy: busy for exactly MD_LATENCY cycles after a
// mult/div start has been in EX.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_i,
  output logic md_busy_o
);

  localparam int CNT_W = $clog2(MD_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (md_start_i) begin
          state_d = MD_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_WAIT: begin
        // A second start here is illegal and deliberately ignored.
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset forces the output low in the same cycle, not just after the edge.
  assign md_busy_o = (state_q == MD_WAIT) && !rst;

  md_start_in_wait: assert property (@(posedge clk) disable iff (rst)
    (state_q == MD_WAIT) |-> !md_start_i);

endmodule

// File: rtl/hazard_stall_unit.sv
// Detects load-use, ID-branch, and HI/LO hazards and drives stall/flush.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int PERF_W     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  input  logic       IF_ID_UseRs,
  input  logic       IF_ID_UseRt,
  input  logic       IF_ID_Branch,
  input  logic       IF_ID_MdStart,
  input  logic       IF_ID_UseHiLo,
  input  logic       ID_Taken,
  input  logic       ID_EX_MemRead,
  input  logic       ID_EX_RegWrite,
  input  logic [4:0] ID_EX_WriteReg,
  input  logic       ID_EX_MdStart,
  input  logic       EX_MEM_MemRead,
  input  logic [4:0] EX_MEM_WriteReg,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       Md_Busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] Stall_Cnt,
  output logic [PERF_W-1:0] Flush_Cnt
`endif
);

  logic ex_dep, mem_dep;
  logic lu_hit, br_hit, md_hit;
  logic stall;

  md_busy_timer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_timer (
    .clk       (clk),
    .rst       (rst),
    .md_start_i(ID_EX_MdStart),
    .md_busy_o (Md_Busy)
  );

  assign ex_dep  = reg_match(ID_EX_WriteReg, IF_ID_UseRs, IF_ID_Rs) |
                   reg_match(ID_EX_WriteReg, IF_ID_UseRt, IF_ID_Rt);
  assign mem_dep = reg_match(EX_MEM_WriteReg, IF_ID_UseRs, IF_ID_Rs) |
                   reg_match(EX_MEM_WriteReg, IF_ID_UseRt, IF_ID_Rt);

  assign lu_hit = ID_EX_MemRead & ex_dep;
  // Branches compare in ID, so even an ALU result one stage ahead is too late.
  assign br_hit = IF_ID_Branch & ((ID_EX_RegWrite & ex_dep) |
                                  (EX_MEM_MemRead & mem_dep));
  assign md_hit = Md_Busy & (IF_ID_UseHiLo | IF_ID_MdStart);

  assign stall = !rst & (lu_hit | br_hit | md_hit);

  assign PC_Write    = !stall;
  assign IF_ID_Write = !stall;
  assign ID_EX_Flush = stall;
  // A stalled branch has not resolved yet, so its outcome must not flush.
  assign IF_ID_Flush = !rst & ID_Taken & !stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (IF_ID_Flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- It is the counterpart to the forwarding unit: it detects the hazards that forwarding cannot resolve and produces the stall and flush controls.
- Hazards covered: load-use, ID-stage branch operand dependency, multi-cycle mult/div HI/LO occupancy, and taken-branch/jump fetch flush.
- Sits between the IF/ID and ID/EX pipeline registers and drives PC/IF_ID write enables and the bubble/flush controls.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit stays busy after a start enters EX; legal range >=1.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- IF_ID_Rs  in  5  ID instruction rs
- IF_ID_Rt  in  5  ID instruction rt
- IF_ID_UseRs  in  1  ID instruction reads rs
- IF_ID_UseRt  in  1  ID instruction reads rt
- IF_ID_Branch  in  1  ID instruction compares registers in ID (beq/bne/jr)
- IF_ID_MdStart  in  1  ID instruction is mult/div
- IF_ID_UseHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- ID_Taken  in  1  branch/jump resolved taken in ID
- ID_EX_MemRead  in  1  EX instruction is a load
- ID_EX_RegWrite  in  1  EX instruction writes a GPR
- ID_EX_WriteReg  in  5  EX destination (already muxed rd/rt)
- ID_EX_MdStart  in  1  EX instruction starts mult/div
- EX_MEM_MemRead  in  1  MEM instruction is a load
- EX_MEM_WriteReg  in  5  MEM destination
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  squash fetched instruction
- ID_EX_Flush  out  1  insert bubble into ID/EX
- Md_Busy  out  1  mult/div occupied

Behaviour:
- Reset: one clock and synchronous active-high reset, named clk and rst.
  - While rst=1: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, Md_Busy=0.
  - On the next edge: state=RUN, counter=0, perf counters=0.
  - Reset mid-MD_WAIT aborts the busy window immediately.
- Hazard terms (combinational, same cycle). Destination register 0 never matches.
  - lu_hit = ID_EX_MemRead & ID_EX_WriteReg!=0 & ((UseRs & WriteReg==Rs) | (UseRt & WriteReg==Rt)).
  - br_hit = IF_ID_Branch & [ (ID_EX_RegWrite & ID_EX_WriteReg match) | (EX_MEM_MemRead & EX_MEM_WriteReg match) ].
    - Match uses the same UseRs/UseRt qualification as lu_hit.
    - A branch behind a load therefore stalls 2 cycles; behind an ALU op, 1 cycle.
  - md_hit = Md_Busy & (IF_ID_UseHiLo | IF_ID_MdStart).
- Stall and flush outputs:
  - stall = lu_hit | br_hit | md_hit.
  - PC_Write = IF_ID_Write = !stall.
  - ID_EX_Flush = stall.
  - IF_ID_Flush = ID_Taken & !stall (a stalled branch has not resolved).
- FSM states:
  - RUN: if ID_EX_MdStart, go to MD_WAIT with counter=MD_LATENCY-1.
  - MD_WAIT: Md_Busy=1. If counter==0, go to RUN; else counter decrements.
  - Result: Md_Busy is high for exactly MD_LATENCY cycles, starting the cycle after the start is in EX.
- Independent instructions are not stalled while Md_Busy=1.
- ID_EX_MdStart while in MD_WAIT is a protocol violation. It is ignored and flagged by a simulation assertion.
- Counter width is $clog2(MD_LATENCY)+1.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs Stall_Cnt and Flush_Cnt, each PERF_W wide.
  - Stall_Cnt increments on every cycle with stall=1.
  - Flush_Cnt increments on every cycle with IF_ID_Flush=1.
  - Both saturate at all-ones and clear on rst.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- hazard_pkg holds:
  - the FSM state enum (RUN, MD_WAIT);
  - REG_ZERO=5'd0;
  - a register-match helper function (dest!=0 & use & equal).
- One sub-module, md_busy_timer: the MD_LATENCY down-counter plus FSM, outputting Md_Busy.
- The top level stays combinational hazard logic plus that instance.

Test Plan:
- Load-use: ID_EX lw, WriteReg=2; IF_ID add, Rs=2, UseRs=1 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Next cycle, with ID_EX a bubble, all outputs are clear.
- Zero destination: same as load-use but WriteReg=0 -> no stall.
- Branch behind load: beq in IF_ID with Rs=3; ID_EX lw $3 -> stall at t. At t+1, EX_MEM_MemRead=1 with WriteReg=3 -> stall. At t+2 released, and ID_Taken=1 yields IF_ID_Flush=1.
- Mult/div timing (MD_LATENCY=4): mult in EX at t; mflo in IF_ID from t+1 -> Md_Busy=1 and stall for t+1..t+4, released at t+5. Independent add in IF_ID at t+2 -> no stall.
- Flush priority: ID_Taken=1 with br_hit=1 -> IF_ID_Flush=0 and stall=1. ID_Taken=1 with no hazard -> IF_ID_Flush=1, PC_Write=1.
- Reset mid-wait: rst=1 during MD_WAIT with counter=2 -> next cycle Md_Busy=0, and a pending mflo is not stalled.
